uart_tx: RTL and testbench

Memory-mapped 8N1 serial transmitter for synthesized builds: the output peripheral downstream of the CPU that consumes byte stores the CPU issues to the terminal address. It sits on the shared bus beside `mem` and `rom`. It buffers bytes in a small FIFO, serializes them LSB-first on `tx`, and raises a level interrupt, suitable for `hwint`, when the transmit path drains.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx transmitter: FSM state encoding,
// register addresses and STATUS register bit positions.
package uart_pkg;

    // Bus and payload widths.
    localparam int unsigned BUS_W  = 32;
    localparam int unsigned DATA_W = 8;

    // Serializer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Register select values on addr.
    localparam logic UART_DATA = 1'b0;
    localparam logic UART_STAT = 1'b1;

    // STATUS read field positions.
    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_BUSY    = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_IRQ_EN  = 4;
    localparam int unsigned STAT_CNT_LSB = 8;
    localparam int unsigned STAT_CNT_W   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   push, din  - write request and data; accepted when not full or when
//                a pop happens in the same cycle
//   pop, dout  - read request; dout always shows the head entry
//   full/empty - occupancy flags
//   count      - number of stored entries (AW+1 bits)
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    always_comb begin
        do_pop_c  = pop && !empty;
        do_push_c = push && (!full || do_pop_c);
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (do_push_c) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop_c) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 serial transmitter with transmit FIFO and level IRQ.
// Ports:
//   clk, rst         - clock, asynchronous active-low reset
//   addr             - 0 = DATA (write pushes a byte), 1 = STATUS/CTRL
//   data             - write data, only [7:0] used
//   out              - read data, driven only while en && rd, else 'z
//   rd, wr, en       - bus read/write strobes and chip select
//   tx               - serial line, idle high, LSB first
//   irq              - registered irq_en && FIFO empty && serializer idle
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr,
    input  logic [BUS_W-1:0]  data,
    output logic [BUS_W-1:0]  out,
    input  logic              rd,
    input  logic              wr,
    input  logic              en,
    output logic              tx,
    output logic              irq
);

    localparam int unsigned BCNT_W = $clog2(CLK_DIV);

    if (CLK_DIV < 2) begin : g_clk_div_chk
        $error("uart_tx: CLK_DIV must be at least 2");
    end

    uart_state_e       state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [2:0]        bitn_q, bitn_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              irq_q, irq_d;
    logic              irq_en_q, irq_en_d;
    logic              ovf_q, ovf_d;

    logic              push_c;
    logic              pop_c;
    logic              ctrl_wr_c;
    logic              bit_end_c;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic [BUS_W-1:0]  rdata_c;
    logic              unused_data_c;

    assign unused_data_c = ^data[BUS_W-1:DATA_W];

    sync_fifo #(
        .WIDTH (DATA_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (data[DATA_W-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Serializer next state; tx is registered from the next state so the
    // line moves on the same edge the state does.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        bitn_d    = bitn_q;
        shreg_d   = shreg_q;
        pop_c     = 1'b0;
        tx_d      = 1'b1;
        bit_end_c = (bcnt_q == BCNT_W'(CLK_DIV - 1));

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shreg_d = fifo_dout;
                    bcnt_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                bcnt_d = bit_end_c ? '0 : bcnt_q + BCNT_W'(1);
                if (bit_end_c) begin
                    bitn_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                bcnt_d = bit_end_c ? '0 : bcnt_q + BCNT_W'(1);
                if (bit_end_c) begin
                    shreg_d = shreg_q >> 1;
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                bcnt_d = bit_end_c ? '0 : bcnt_q + BCNT_W'(1);
                if (bit_end_c) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shreg_d = fifo_dout;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Bus writes, overflow tracking and interrupt condition.
    always_comb begin
        push_c    = en && wr && (addr == UART_DATA);
        ctrl_wr_c = en && wr && (addr == UART_STAT);
        irq_en_d  = irq_en_q;
        ovf_d     = ovf_q;
        if (push_c && fifo_full && !pop_c) begin
            ovf_d = 1'b1;
        end
        if (ctrl_wr_c) begin
            irq_en_d = data[0];
            if (data[1]) begin
                ovf_d = 1'b0;
            end
        end
        irq_d = irq_en_q && fifo_empty && (state_q == ST_IDLE);
    end

    // Read mux; DATA reads return zero.
    always_comb begin
        rdata_c = '0;
        if (addr == UART_STAT) begin
            rdata_c[STAT_FULL]                     = fifo_full;
            rdata_c[STAT_EMPTY]                    = fifo_empty;
            rdata_c[STAT_BUSY]                     = (state_q != ST_IDLE);
            rdata_c[STAT_OVF]                      = ovf_q;
            rdata_c[STAT_IRQ_EN]                   = irq_en_q;
            rdata_c[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
        end
    end

    assign out = (en && rd) ? rdata_c : 'z;
    assign tx  = tx_q;
    assign irq = irq_q;

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            bcnt_q   <= '0;
            bitn_q   <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            irq_q    <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            bitn_q   <= bitn_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            irq_q    <= irq_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a timeline model predicts when each byte
// leaves the FIFO, a line receiver decodes tx and checks byte and start cycle.
module tb_uart_tx;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned FIFO_AW = 3;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned FRAME   = 10 * CLK_DIV;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        addr = 1'b0;
    logic        rd   = 1'b0;
    logic        wr   = 1'b0;
    logic        en   = 1'b0;
    logic [31:0] data = 32'h0;
    wire  [31:0] out;
    logic        tx;
    logic        irq;

    uart_tx #(
        .CLK_DIV (CLK_DIV),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data),
        .out  (out),
        .rd   (rd),
        .wr   (wr),
        .en   (en),
        .tx   (tx),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_z(input string name);
        checks++;
        if (!((out === 32'hz) || (out === 32'h0))) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected high-impedance", name, out);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0]  b;
        int unsigned c;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mq[$];
    int unsigned cyc      = 0;
    int unsigned m_free   = 0;
    bit          m_busy   = 1'b0;
    bit          m_irq    = 1'b0;
    bit          m_irq_en = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_irq_n  = 1'b0;
    bit          chk_on   = 1'b0;

    // The line is free at edge m_free; a waiting byte leaves at the first edge
    // at or after that, and its frame occupies FRAME cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            sb.delete();
            m_free   = 0;
            m_busy   = 1'b0;
            m_irq    = 1'b0;
            m_irq_en = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            cyc++;
            m_irq_n = m_irq_en && (mq.size() == 0) && !m_busy;
            if (cyc >= m_free && mq.size() > 0) begin
                sb.push_back('{b: mq.pop_front(), c: cyc});
                m_free = cyc + FRAME;
            end
            if (en && wr && addr == 1'b0) begin
                if (mq.size() < DEPTH) mq.push_back(data[7:0]);
                else m_ovf = 1'b1;
            end
            if (en && wr && addr == 1'b1) begin
                m_irq_en = data[0];
                if (data[1]) m_ovf = 1'b0;
            end
            m_busy = (cyc < m_free);
            m_irq  = m_irq_n;
        end
    end

    function automatic logic [31:0] m_stat();
        return {16'h0, 8'(mq.size()), 3'b0, m_irq_en, m_ovf, m_busy,
                (mq.size() == 0), (mq.size() == DEPTH)};
    endfunction

    // ---------------- line monitor ----------------
    logic [7:0]  mon_b;
    bit          mon_ok;
    bit          mon_abort;
    int unsigned mon_start;
    int unsigned mon_k;
    exp_t        mon_e;

    always begin
        @(negedge clk);
        if (rst && tx === 1'b0) begin
            mon_start = cyc;
            mon_abort = 1'b0;
            mon_ok    = 1'b1;
            mon_b     = 8'h0;
            for (int off = 1; off < FRAME; off++) begin
                @(negedge clk);
                if (!rst) begin
                    mon_abort = 1'b1;
                    break;
                end
                if (off % CLK_DIV == CLK_DIV / 2) begin
                    mon_k = off / CLK_DIV;
                    if (mon_k == 0) begin
                        if (tx !== 1'b0) mon_ok = 1'b0;
                    end else if (mon_k <= 8) begin
                        mon_b[mon_k-1] = tx;
                    end else if (tx !== 1'b1) begin
                        mon_ok = 1'b0;
                    end
                end
            end
            if (!mon_abort) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_frame: got byte 0x%02h at cycle %0d, expected no frame",
                             mon_b, mon_start);
                end else begin
                    mon_e = sb.pop_front();
                    chk("frame_byte", {24'h0, mon_b}, {24'h0, mon_e.b});
                    chk("frame_start_cycle", mon_start, mon_e.c);
                    chk("frame_start_stop_bits", {31'h0, mon_ok}, 32'h1);
                end
            end
        end
    end

    // Continuous interrupt and idle-line comparison.
    always @(negedge clk) begin
        if (rst && chk_on) begin
            chk("irq", {31'h0, irq}, {31'h0, m_irq});
            if (!m_busy) chk("tx_idle_high", {31'h0, tx}, 32'h1);
        end
    end

    // ---------------- bus driver ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic a, input logic [31:0] d);
        en   = 1'b1;
        wr   = 1'b1;
        addr = a;
        data = d;
        @(posedge clk);
        #1;
        en   = 1'b0;
        wr   = 1'b0;
        data = 32'h0;
    endtask

    task automatic bus_rd(input logic a, output logic [31:0] v);
        en   = 1'b1;
        rd   = 1'b1;
        addr = a;
        #1;
        v  = out;
        en = 1'b0;
        rd = 1'b0;
        #1;
    endtask

    task automatic read_stat(input string name, output logic [31:0] v);
        logic [31:0] e;
        e = m_stat();
        bus_rd(1'b1, v);
        chk(name, v, e);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((mq.size() != 0 || m_busy || sb.size() != 0) && n < max) begin
            idle(1);
            n++;
        end
        chk("drain_within_budget", {31'h0, n < max}, 32'h1);
    endtask

    function automatic logic [31:0] rnd_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h77) b = 8'h76;
        return {24'h0, b};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    logic [31:0] v;
    int          n;
    int          op;

    initial begin
        // Reset state
        #23;
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk_z("rst_out_z");
        bus_rd(1'b1, v);
        chk("rst_status", v, 32'h0000_0002);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_on = 1'b1;
        idle(2);

        // Single byte, latency and DATA read
        bus_wr(1'b0, 32'h0000_00A5);
        chk("latency_tx_before", {31'h0, tx}, 32'h1);
        idle(1);
        chk("latency_tx_fall", {31'h0, tx}, 32'h0);
        bus_rd(1'b0, v);
        chk("data_read_zero", v, 32'h0);
        drain(200);

        // Interrupt enable, three back-to-back bytes
        bus_wr(1'b1, 32'h1);
        idle(2);
        bus_wr(1'b0, rnd_byte());
        bus_wr(1'b0, rnd_byte());
        bus_wr(1'b0, rnd_byte());
        read_stat("stat_after_first_pop", v);
        chk("count_after_first_pop", {24'h0, v[15:8]}, 32'h2);
        drain(300);
        idle(2);
        chk("irq_after_drain", {31'h0, irq}, 32'h1);

        // Overflow: one byte in flight plus eight queued, ninth dropped
        for (int i = 0; i < 9; i++) bus_wr(1'b0, rnd_byte());
        bus_wr(1'b0, 32'h0000_0077);
        read_stat("stat_overflow", v);
        chk("ovf_set", {31'h0, v[3]}, 32'h1);
        chk("full_set", {31'h0, v[0]}, 32'h1);
        bus_wr(1'b1, 32'h2);
        read_stat("stat_ovf_cleared", v);
        chk("ovf_cleared", {31'h0, v[3]}, 32'h0);

        // Push on the very edge the serializer pops from a full FIFO
        n = 0;
        while (cyc + 1 != m_free && n < 100) begin
            idle(1);
            n++;
        end
        chk("pop_edge_found", {31'h0, n < 100}, 32'h1);
        bus_wr(1'b0, 32'h0000_003C);
        read_stat("stat_push_on_pop", v);
        chk("count_push_on_pop", {24'h0, v[15:8]}, 32'h8);
        chk("ovf_push_on_pop", {31'h0, v[3]}, 32'h0);
        drain(800);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                bus_wr(1'b0, rnd_byte());
            end else if (op == 6) begin
                bus_wr(1'b1, {30'h0, 2'($urandom)});
            end else if (op == 7) begin
                read_stat("stat_random", v);
            end else if (op == 8) begin
                bus_rd(1'b0, v);
                chk("data_read_random", v, 32'h0);
            end else begin
                idle(int'($urandom_range(1, 45)));
            end
        end
        drain(2000);

        // Reset in the middle of a data bit
        bus_wr(1'b1, 32'h1);
        bus_wr(1'b0, 32'h0000_005A);
        idle(15);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_tx", {31'h0, tx}, 32'h1);
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        bus_rd(1'b1, v);
        chk("midrst_status", v, 32'h0000_0002);
        chk_z("midrst_out_z");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(80);
        chk("midrst_no_residual_frame", {31'h0, tx}, 32'h1);

        // Final bookkeeping
        chk("scoreboard_empty", sb.size(), 32'h0);
        chk("model_fifo_empty", mq.size(), 32'h0);
        chk_z("idle_bus_out_z");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
